// File: rtl/stack_seq.sv
// Stack access sequencer: expands CALL/RET/RETI/PUSH/POP into ordered one-byte
// stack accesses. Optional STACK_CHK_EN adds sticky overflow/underflow flags.
`ifndef WR_RAM_STACK
`define WR_RAM_STACK 4'h2
`endif
`ifndef RD_RAM_STACK
`define RD_RAM_STACK 4'h3
`endif

module stack_seq #(
  parameter int RAM_RD_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_call,
  input  logic        start_ret,
  input  logic        start_reti,
  input  logic        start_push,
  input  logic        start_pop,
  input  logic [15:0] pc,
  input  logic [7:0]  push_data,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  ram_rd_data,
  output logic [3:0]  ram_sel,
  output logic [7:0]  ram_wr_data,
  output logic        busy,
  output logic        done,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        pop_valid,
  output logic [7:0]  pop_data,
  output logic        reti_clr,
  output logic        stack_ovf,
  output logic        stack_unf,
  input  logic        err_clr
);

  localparam logic [3:0] SEL_NONE = 4'h0;
  localparam logic [3:0] SEL_WR   = `WR_RAM_STACK;
  localparam logic [3:0] SEL_RD   = `RD_RAM_STACK;

  if (RAM_RD_LAT != 1) begin : g_lat_chk
    $error("stack_seq: only RAM_RD_LAT == 1 is supported");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CALL_LO, S_CALL_HI, S_RET_HI, S_RET_LO, S_RET_CAP,
    S_PUSH1, S_POP1, S_POP_CAP, S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  pc_hi_q;
  logic        reti_q;
  logic [3:0]  ram_sel_q;
  logic [7:0]  ram_wr_data_q;
  logic        busy_q, done_q, pc_load_q, pop_valid_q, reti_clr_q;
  logic [15:0] pc_new_q;
  logic [7:0]  pop_data_q;

  // Outputs are registered alongside the state they belong to, so each
  // output reflects the state being entered on this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_hi_q       <= 8'h00;
      reti_q        <= 1'b0;
      ram_sel_q     <= SEL_NONE;
      ram_wr_data_q <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_load_q     <= 1'b0;
      pop_valid_q   <= 1'b0;
      reti_clr_q    <= 1'b0;
      pc_new_q      <= 16'h0000;
      pop_data_q    <= 8'h00;
    end else begin
      ram_sel_q   <= SEL_NONE;
      done_q      <= 1'b0;
      pc_load_q   <= 1'b0;
      pop_valid_q <= 1'b0;
      reti_clr_q  <= 1'b0;
      busy_q      <= 1'b1;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start_call) begin
            state_q       <= S_CALL_LO;
            pc_hi_q       <= pc[15:8];
            ram_sel_q     <= SEL_WR;
            ram_wr_data_q <= pc[7:0];
            busy_q        <= 1'b1;
          end else if (start_reti || start_ret) begin
            state_q   <= S_RET_HI;
            reti_q    <= start_reti;
            ram_sel_q <= SEL_RD;
            busy_q    <= 1'b1;
          end else if (start_push) begin
            state_q       <= S_PUSH1;
            ram_sel_q     <= SEL_WR;
            ram_wr_data_q <= push_data;
            busy_q        <= 1'b1;
          end else if (start_pop) begin
            state_q   <= S_POP1;
            ram_sel_q <= SEL_RD;
            busy_q    <= 1'b1;
          end
        end
        S_CALL_LO: begin
          state_q       <= S_CALL_HI;
          ram_sel_q     <= SEL_WR;
          ram_wr_data_q <= pc_hi_q;
        end
        S_CALL_HI: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_RET_HI: begin
          state_q   <= S_RET_LO;
          ram_sel_q <= SEL_RD;
        end
        S_RET_LO: begin
          state_q        <= S_RET_CAP;
          pc_new_q[15:8] <= ram_rd_data;
        end
        S_RET_CAP: begin
          state_q       <= S_DONE;
          pc_new_q[7:0] <= ram_rd_data;
          done_q        <= 1'b1;
          pc_load_q     <= 1'b1;
          reti_clr_q    <= reti_q;
        end
        S_PUSH1: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_POP1: begin
          state_q <= S_POP_CAP;
        end
        S_POP_CAP: begin
          state_q     <= S_DONE;
          pop_data_q  <= ram_rd_data;
          done_q      <= 1'b1;
          pop_valid_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_sel     = ram_sel_q;
  assign ram_wr_data = ram_wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pc_load     = pc_load_q;
  assign pc_new      = pc_new_q;
  assign pop_valid   = pop_valid_q;
  assign pop_data    = pop_data_q;
  assign reti_clr    = reti_clr_q;

`ifdef STACK_CHK_EN
  logic ovf_q, unf_q;

  // A set event in the same cycle as err_clr takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ram_sel_q == SEL_WR && sp_in == 8'hFF) ovf_q <= 1'b1;
      else if (err_clr)                          ovf_q <= 1'b0;
      if (ram_sel_q == SEL_RD && sp_in <= 8'h07) unf_q <= 1'b1;
      else if (err_clr)                          unf_q <= 1'b0;
    end
  end

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  logic unused_chk;
  assign unused_chk = ^{err_clr, sp_in};
  assign stack_ovf  = 1'b0;
  assign stack_unf  = 1'b0;
`endif

endmodule

// File: doc/stack_seq.md
# stack_seq

Multi-cycle stack access sequencer for the 8051 core. It sits directly upstream of the stack pointer block and drives its `ram_sel` input. It also supplies write data to, and captures read data from, internal RAM. It turns single-cycle requests from the instruction decoder (CALL, RET/RETI, PUSH, POP) into an ordered series of one-byte stack accesses, and returns the recovered PC or byte to the core.

## Interface
Parameters:
- `RAM_RD_LAT`, default 1: cycles from a `RD_RAM_STACK` cycle to valid `ram_rd_data`. Only the value 1 is supported.

Ports:
- `clock`  in  1  core clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `start_call`  in  1  one-cycle request: push PC (ACALL/LCALL/interrupt vector entry)
- `start_ret`  in  1  one-cycle request: pop PC (RET)
- `start_reti`  in  1  one-cycle request: pop PC and release interrupt level (RETI)
- `start_push`  in  1  one-cycle request: push `push_data`
- `start_pop`  in  1  one-cycle request: pop one byte
- `pc`  in  16  return address, sampled in the start cycle
- `push_data`  in  8  byte to push, sampled in the start cycle
- `sp_in`  in  8  current stack pointer value (the SP block's `sp_out`)
- `ram_rd_data`  in  8  internal RAM read data
- `ram_sel`  out  4  RAM access select: `` `WR_RAM_STACK ``, `` `RD_RAM_STACK ``, or 4'h0 (no stack access)
- `ram_wr_data`  out  8  byte to write during `` `WR_RAM_STACK `` cycles
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse: sequence complete
- `pc_load`  out  1  one-cycle pulse: `pc_new` valid and must be loaded
- `pc_new`  out  16  popped return address
- `pop_valid`  out  1  one-cycle pulse: `pop_data` valid
- `pop_data`  out  8  popped byte
- `reti_clr`  out  1  one-cycle pulse: clear in-service interrupt priority
- `stack_ovf`  out  1  sticky overflow flag (only with `STACK_CHK_EN`)
- `stack_unf`  out  1  sticky underflow flag (only with `STACK_CHK_EN`)
- `err_clr`  in  1  clears `stack_ovf` and `stack_unf`

## Operation
- FSM states: IDLE, CALL_LO, CALL_HI, RET_HI, RET_LO, RET_CAP, PUSH1, POP1, POP_CAP, DONE.
- All outputs are decoded from registered state and registered data (Moore outputs).
- Start acceptance:
  - Starts are sampled only in IDLE; starts are ignored while `busy`=1.
  - Simultaneous starts resolve by priority: call > reti > ret > push > pop. Lower-priority requests are dropped.
  - The accepting edge latches `pc` or `push_data` and a `reti` flag.
- CALL: CALL_LO (WR, data=pc[7:0]) → CALL_HI (WR, data=pc[15:8]) → DONE. This matches 8051 order: low byte at SP+1, high byte at SP+2.
- RET/RETI: RET_HI (RD) → RET_LO (RD; capture `ram_rd_data` into pc_new[15:8]) → RET_CAP (no access; capture pc_new[7:0]) → DONE.
  - DONE asserts `pc_load`.
  - If the flag is set, DONE also asserts `reti_clr`.
- PUSH: PUSH1 (WR, data=latched byte) → DONE.
- POP: POP1 (RD) → POP_CAP (capture) → DONE. DONE asserts `pop_valid`.
- DONE always asserts `done` for one cycle and returns to IDLE. A new start is accepted in the cycle after DONE.
- `busy` = 1 in every state except IDLE.
- `ram_sel` = 4'h0 in IDLE, RET_CAP, POP_CAP and DONE.
- Addressing is owned by the SP block: SP pre-increments on WR, post-decrements on RD, and will not decrement below 8'h07. This block never computes addresses.
- `pc_new` and `pop_data` hold their values until the next capture.

## Timing
- Reset values: state IDLE, `ram_sel`=4'h0, `ram_wr_data`=8'h00, `pc_new`=16'h0000, `pop_data`=8'h00. All pulses and flags are 0.
- Latency from the start edge to the `done` pulse:
  - CALL: 3 cycles
  - RET/RETI: 4 cycles
  - PUSH: 2 cycles
  - POP: 3 cycles
- The read data for the RD issued in cycle n is valid in cycle n+1 and is captured on edge n+1.
- Reset mid-sequence: the next edge forces IDLE with `ram_sel`=0. No `pc_load`, `pop_valid` or `reti_clr` pulse is produced for the aborted sequence. Bytes already written remain in RAM.
- `err_clr` and a flag-set event in the same cycle: the set wins.

## Configuration
- `STACK_CHK_EN` defined:
  - `stack_ovf` sets on any WR cycle with `sp_in`==8'hFF (wrap to 8'h00).
  - `stack_unf` sets on any RD cycle with `sp_in`<=8'h07.
  - Both flags are sticky until `err_clr` or `reset`.
  - Sequencing is unaffected.
- `STACK_CHK_EN` not defined: both flags are tied to 0, `err_clr` is ignored, and no checker logic is generated.

## Test plan
- Reset, then `start_call` with pc=16'h1234 and SP=8'h07:
  - RAM[08]=8'h34 and RAM[09]=8'h12.
  - `done` pulses 3 cycles after the start edge.
  - SP ends at 8'h09.
- From the previous state, `start_reti`:
  - `pc_new`=16'h1234.
  - `pc_load` and `reti_clr` pulse in the same cycle, 4 cycles after the start edge.
  - SP=8'h07.
- `start_push` with push_data=8'hA5, then `start_pop` after `done`:
  - `pop_data`=8'hA5 and `pop_valid` pulses.
  - SP returns to its starting value.
- `start_call` and `start_pop` asserted together, then `start_push` asserted while `busy`:
  - Only the CALL sequence runs.
  - No PUSH write occurs.
- Reset asserted in RET_LO:
  - Next cycle is IDLE with `ram_sel`=0.
  - No `pc_load` pulse.
- With `STACK_CHK_EN` and SP=8'hFE, `start_call`:
  - `stack_ovf`=1 after the second write.
  - `err_clr` clears it.
  - Without the macro, the flag stays 0.
